i2c_bit_ctrl: RTL and testbench
===============================

# i2c_bit_ctrl

Bit-level sequencer for the I2C master. It turns single-bit commands (START, STOP, WRITE, READ) into timed open-drain SCL/SDA waveforms. It also handles slave clock stretching, detects lost arbitration and tracks bus-busy state. It sits between the byte-level I2C master FSM and the open-drain pad drivers.

## Interface
- CLK_DIV, 250: quarter-SCL-period length in i_clk cycles; minimum 4. At 100 MHz, 250 gives 100 kHz.
- STRETCH_MAX, 65535: maximum cycles SCL may be held low by a slave. Used only when I2C_STRETCH_TIMEOUT_EN is defined.
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command request
- i_cmd  in  3  1=START, 2=STOP, 3=WRITE, 4=READ; other codes are NOP
- i_wr_bit  in  1  data bit for WRITE; sampled when the command is accepted
- o_cmd_ready  out  1  high when idle; a command is accepted when i_cmd_valid & o_cmd_ready
- o_done  out  1  one-cycle pulse when a command completes normally
- o_rd_bit  out  1  bit sampled by READ; holds its value until the next READ completes
- o_arb_lost  out  1  one-cycle pulse when arbitration is lost
- o_timeout  out  1  one-cycle pulse when the stretch timeout fires; tied 0 without the macro
- o_bus_busy  out  1  high between a detected START and the next detected STOP, from any master
- i_scl, i_sda  in  1 each  pad inputs, asynchronous
- o_scl_oe, o_sda_oe  out  1 each  1 drives the line low, 0 releases it

## Operation
- i_scl and i_sda pass through a 2-flop synchronizer to give s_scl and s_sda. Previous-cycle copies of both are kept for edge detection.
- FSM states: IDLE, then phases A, B, C, D; each phase is CLK_DIV cycles.
- In IDLE, o_cmd_ready=1. On acceptance the FSM latches cmd and wr_bit and moves to A.
- A NOP command skips the phases: o_done pulses the next cycle and the lines do not change.
- Line drive per phase (SCL oe / SDA oe, 1 = low):
  - START: A 0/0, B 0/0, C 0/1, D 1/1
  - STOP: A 1/1, B 0/1, C 0/1, D 0/0
  - WRITE: A 1/~b, B 0/~b, C 0/~b, D 1/~b
  - READ: A 1/0, B 0/0, C 0/0, D 1/0
- Clock stretching: in any phase with SCL released, the phase counter holds at 0 while s_scl==0. Counting starts on the first cycle s_scl==1.
- READ: o_rd_bit takes s_sda in the last cycle of phase C.
- Arbitration applies to WRITE with b=1 and to STOP phase D. If s_sda==0 while SDA is released and s_scl==1:
  - release both lines, pulse o_arb_lost, return to IDLE;
  - no o_done.
- Bus busy:
  - s_sda falling while s_scl==1 (previous and current) sets o_bus_busy;
  - s_sda rising while s_scl==1 clears it.
  - The bus monitor runs in every state, including while this block drives the lines.

## Timing
- Reset values: o_scl_oe=0, o_sda_oe=0, o_cmd_ready=1, o_done=0, o_rd_bit=0, o_arb_lost=0, o_timeout=0, o_bus_busy=0, FSM=IDLE. Lines are released immediately on reset assertion, including mid-command.
- All outputs are registered.
- o_cmd_ready falls the cycle after acceptance.
- o_done and o_cmd_ready=1 assert in the same cycle: the cycle after phase D's final count.
- A new command may be accepted in that same cycle; back-to-back issue has no gap cycle.
- Latency with an ideal pull-up and no stretching:
  - each SCL low→release transition adds 2 synchronizer cycles;
  - WRITE/READ: 4*CLK_DIV+2 cycles from acceptance to o_done;
  - START with SCL already high: 4*CLK_DIV.
- o_arb_lost: registered pulse, 1 cycle after the offending s_sda sample.
- o_bus_busy updates 3 cycles after the pad edge (2 sync + 1 register).
- If valid is held during a busy command, nothing is accepted until ready returns.

## Configuration
- I2C_STRETCH_TIMEOUT_EN defined: a counter runs while a phase waits on s_scl==0. On reaching STRETCH_MAX:
  - o_timeout pulses one cycle;
  - both lines are released;
  - the FSM returns to IDLE with no o_done.
- I2C_STRETCH_TIMEOUT_EN undefined: the FSM waits indefinitely, and o_timeout is constant 0.

## Test plan
- Reset, then CLK_DIV=4, ideal pull-ups, START from idle → SDA falls while SCL high. o_done arrives 16 cycles after acceptance, ending with SCL and SDA low. o_bus_busy=1.
- WRITE b=1 then WRITE b=0 issued back-to-back → SDA is stable through every SCL-high window. Each o_done comes 18 cycles after its acceptance, with no idle gap.
- READ while the bench holds SDA low during SCL high → o_rd_bit=0. Repeat with SDA released → o_rd_bit=1.
- Slave holds SCL low for 40 cycles after release in phase B of a WRITE → o_done is delayed by 40 cycles versus the unstretched case.
- WRITE b=1 while the bench pulls SDA low during SCL high → o_arb_lost pulses and o_done stays 0. Both oe are 0 the next cycle, then o_cmd_ready=1.
- With I2C_STRETCH_TIMEOUT_EN and STRETCH_MAX=100, SCL stuck low → o_timeout pulses once, both lines are released, and FSM is IDLE. Assert i_rst_n=0 mid-WRITE → all oe are 0 at once.

Source files
------------

// File: rtl/i2c_bit_ctrl.sv
// I2C master bit sequencer: START/STOP/WRITE/READ to timed open-drain SCL/SDA with stretching,
// arbitration-loss detection and bus-busy tracking. Optional macro: I2C_STRETCH_TIMEOUT_EN.
module i2c_bit_ctrl #(
  parameter int unsigned CLK_DIV     = 250,
  parameter int unsigned STRETCH_MAX = 65535
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  input  logic [2:0] i_cmd,
  input  logic       i_wr_bit,
  output logic       o_cmd_ready,
  output logic       o_done,
  output logic       o_rd_bit,
  output logic       o_arb_lost,
  output logic       o_timeout,
  output logic       o_bus_busy,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_scl_oe,
  output logic       o_sda_oe
);

  localparam logic [2:0] CmdStart = 3'd1;
  localparam logic [2:0] CmdStop  = 3'd2;
  localparam logic [2:0] CmdWrite = 3'd3;
  localparam logic [2:0] CmdRead  = 3'd4;

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StA, StB, StC, StD} state_e;

  state_e          state_q, state_d, ph_next;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      cmd_q, cmd_d;
  logic            wr_q, wr_d;
  logic            scl_oe_d, sda_oe_d, ready_d, done_d, rd_d, arb_d, busy_d;
  logic            scl_ff1, sda_ff1, s_scl, s_sda, scl_prev, sda_prev;
  logic            sda_oe_p1, sda_oe_p2;
  logic            wait_scl, arb_hit, is_op;

  // {scl_oe, sda_oe} for a given command and phase; 1 pulls the line low.
  function automatic logic [1:0] phase_drive(input logic [2:0] cmd, input logic b,
                                             input state_e ph);
    logic [1:0] d;
    d = 2'b00;
    case (cmd)
      CmdStart: d = (ph == StC) ? 2'b01 : (ph == StD) ? 2'b11 : 2'b00;
      CmdStop:  d = (ph == StA) ? 2'b11 : (ph == StD) ? 2'b00 : 2'b01;
      CmdWrite: d = {(ph == StA) || (ph == StD), ~b};
      CmdRead:  d = {(ph == StA) || (ph == StD), 1'b0};
      default:  d = 2'b00;
    endcase
    return d;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_ff1   <= 1'b1;
      sda_ff1   <= 1'b1;
      s_scl     <= 1'b1;
      s_sda     <= 1'b1;
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
      sda_oe_p1 <= 1'b0;
      sda_oe_p2 <= 1'b0;
    end else begin
      scl_ff1   <= i_scl;
      sda_ff1   <= i_sda;
      s_scl     <= scl_ff1;
      s_sda     <= sda_ff1;
      scl_prev  <= s_scl;
      sda_prev  <= s_sda;
      sda_oe_p1 <= o_sda_oe;
      sda_oe_p2 <= sda_oe_p1;
    end
  end

`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam int unsigned SW = $clog2(STRETCH_MAX + 1);
  localparam logic [SW-1:0] StretchLast = SW'(STRETCH_MAX - 1);
  logic [SW-1:0] stretch_q, stretch_d;
  logic          tmo_d;
`endif

  assign is_op    = (i_cmd >= CmdStart) && (i_cmd <= CmdRead);
  assign wait_scl = !o_scl_oe && !s_scl;
  // sda_oe_p2 lines up our SDA drive with the synchronizer delay, so a line we just released
  // is not mistaken for another master holding it low.
  assign arb_hit  = (((cmd_q == CmdWrite) && wr_q) || ((cmd_q == CmdStop) && (state_q == StD)))
                    && !o_sda_oe && !sda_oe_p2 && !s_sda && s_scl;

  always_comb begin
    case (state_q)
      StA:     ph_next = StB;
      StB:     ph_next = StC;
      StC:     ph_next = StD;
      default: ph_next = StIdle;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    wr_d     = wr_q;
    scl_oe_d = o_scl_oe;
    sda_oe_d = o_sda_oe;
    ready_d  = o_cmd_ready;
    done_d   = 1'b0;
    arb_d    = 1'b0;
    rd_d     = o_rd_bit;
`ifdef I2C_STRETCH_TIMEOUT_EN
    stretch_d = '0;
    tmo_d     = 1'b0;
`endif
    if (state_q == StIdle) begin
      cnt_d = '0;
      if (i_cmd_valid) begin
        if (is_op) begin
          cmd_d                = i_cmd;
          wr_d                 = i_wr_bit;
          state_d              = StA;
          ready_d              = 1'b0;
          {scl_oe_d, sda_oe_d} = phase_drive(i_cmd, i_wr_bit, StA);
        end else begin
          done_d = 1'b1;
        end
      end
    end else if (arb_hit) begin
      state_d              = StIdle;
      ready_d              = 1'b1;
      arb_d                = 1'b1;
      {scl_oe_d, sda_oe_d} = 2'b00;
    end else if (wait_scl) begin
      cnt_d = '0;
`ifdef I2C_STRETCH_TIMEOUT_EN
      stretch_d = stretch_q + SW'(1);
      if (stretch_q == StretchLast) begin
        stretch_d            = '0;
        tmo_d                = 1'b1;
        state_d              = StIdle;
        ready_d              = 1'b1;
        {scl_oe_d, sda_oe_d} = 2'b00;
      end
`endif
    end else begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        if ((state_q == StC) && (cmd_q == CmdRead)) begin
          rd_d = s_sda;
        end
        if (state_q == StD) begin
          state_d = StIdle;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d              = ph_next;
          {scl_oe_d, sda_oe_d} = phase_drive(cmd_q, wr_q, ph_next);
        end
      end
    end
  end

  // START/STOP detection from the synchronized lines, independent of our own FSM.
  always_comb begin
    busy_d = o_bus_busy;
    if (scl_prev && s_scl && sda_prev && !s_sda) begin
      busy_d = 1'b1;
    end else if (scl_prev && s_scl && !sda_prev && s_sda) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cmd_q       <= 3'd0;
      wr_q        <= 1'b0;
      o_scl_oe    <= 1'b0;
      o_sda_oe    <= 1'b0;
      o_cmd_ready <= 1'b1;
      o_done      <= 1'b0;
      o_rd_bit    <= 1'b0;
      o_arb_lost  <= 1'b0;
      o_bus_busy  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      wr_q        <= wr_d;
      o_scl_oe    <= scl_oe_d;
      o_sda_oe    <= sda_oe_d;
      o_cmd_ready <= ready_d;
      o_done      <= done_d;
      o_rd_bit    <= rd_d;
      o_arb_lost  <= arb_d;
      o_bus_busy  <= busy_d;
    end
  end

`ifdef I2C_STRETCH_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stretch_q <= '0;
      o_timeout <= 1'b0;
    end else begin
      stretch_q <= stretch_d;
      o_timeout <= tmo_d;
    end
  end
`else
  logic unused_stretch_max;
  assign unused_stretch_max = ^STRETCH_MAX;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Directed bench for i2c_bit_ctrl: ideal pull-ups with a bench-side slave that can stretch SCL
// or hold SDA low; expected completions are queued at issue and popped at o_done.
module tb_i2c_bit_ctrl;
  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       wr_bit;
  logic       cmd_ready, done, rd_bit, arb_lost, timeout, bus_busy;
  logic       scl_oe, sda_oe;
  logic       scl_pad, sda_pad;
  logic       slave_scl_low, slave_sda_low;
  logic       mon_en;
  logic       scl_pad_prev, sda_pad_prev;
  int         glitches;
  int         tests;
  int         fails;

  typedef struct {
    int         lat;
    logic       chk_rd;
    logic       rd;
    logic [1:0] oe;
  } exp_t;
  exp_t sb[$];

  assign scl_pad = ~(scl_oe | slave_scl_low);
  assign sda_pad = ~(sda_oe | slave_sda_low);

  i2c_bit_ctrl #(
    .CLK_DIV    (N),
    .STRETCH_MAX(100)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cmd_valid(cmd_valid),
    .i_cmd      (cmd),
    .i_wr_bit   (wr_bit),
    .o_cmd_ready(cmd_ready),
    .o_done     (done),
    .o_rd_bit   (rd_bit),
    .o_arb_lost (arb_lost),
    .o_timeout  (timeout),
    .o_bus_busy (bus_busy),
    .i_scl      (scl_pad),
    .i_sda      (sda_pad),
    .o_scl_oe   (scl_oe),
    .o_sda_oe   (sda_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data must not move while SCL is high during WRITE bits.
  always @(posedge clk) begin
    if (mon_en && scl_pad_prev && scl_pad && (sda_pad != sda_pad_prev)) glitches <= glitches + 1;
    scl_pad_prev <= scl_pad;
    sda_pad_prev <= sda_pad;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [2:0] c, input logic b);
    chk({tag, ".ready_before"}, 32'(cmd_ready), 32'd1);
    cmd       = c;
    wr_bit    = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = 3'd0;
    if (c >= 3'd1 && c <= 3'd4) chk({tag, ".ready_fall"}, 32'(cmd_ready), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] c, input logic b, input int lat,
                         input logic chk_rd, input logic rd, input logic [1:0] oe);
    exp_t e;
    int   n;
    sb.push_back('{lat: lat, chk_rd: chk_rd, rd: rd, oe: oe});
    issue(tag, c, b);
    n = 0;
    while (done !== 1'b1 && arb_lost !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".latency"}, 32'(n), 32'(e.lat));
    chk({tag, ".oe"}, 32'({scl_oe, sda_oe}), 32'(e.oe));
    chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    if (e.chk_rd) chk({tag, ".rd_bit"}, 32'(rd_bit), 32'(e.rd));
  endtask

  task automatic stretch_proc();
    int k;
    @(posedge clk);
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (!scl_oe) break;
      k++;
    end
    repeat (40) @(posedge clk);
    #1;
    slave_scl_low = 1'b0;
  endtask

  initial begin
    int k;
    logic seen_done;
    logic seen;
    tests = 0;
    fails = 0;
    glitches = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd = 3'd0;
    wr_bit = 1'b0;
    slave_scl_low = 1'b0;
    slave_sda_low = 1'b0;
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.oe", 32'({scl_oe, sda_oe}), 32'd0);
    chk("rst.ready", 32'(cmd_ready), 32'd1);
    chk("rst.flags", 32'({done, rd_bit, arb_lost, timeout, bus_busy}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    run_cmd("start", 3'd1, 1'b0, 4 * N, 1'b0, 1'b0, 2'b11);
    chk("start.busy", 32'(bus_busy), 32'd1);
    run_cmd("nop", 3'd0, 1'b0, 0, 1'b0, 1'b0, 2'b11);

    mon_en = 1'b1;
    run_cmd("wr1", 3'd3, 1'b1, 4 * N + 2, 1'b0, 1'b0, 2'b10);
    run_cmd("wr0", 3'd3, 1'b0, 4 * N + 2, 1'b0, 1'b0, 2'b11);
    mon_en = 1'b0;
    chk("wr.sda_stable", 32'(glitches), 32'd0);

    slave_sda_low = 1'b1;
    run_cmd("rd0", 3'd4, 1'b0, 4 * N + 2, 1'b1, 1'b0, 2'b10);
    slave_sda_low = 1'b0;
    run_cmd("rd1", 3'd4, 1'b0, 4 * N + 2, 1'b1, 1'b1, 2'b10);

    slave_scl_low = 1'b1;
    fork
      run_cmd("wr_stretch", 3'd3, 1'b0, 4 * N + 2 + 40, 1'b0, 1'b0, 2'b11);
      stretch_proc();
    join

    run_cmd("stop", 3'd2, 1'b0, 4 * N + 2, 1'b0, 1'b0, 2'b00);
    chk("stop.busy", 32'(bus_busy), 32'd0);
    run_cmd("start2", 3'd1, 1'b0, 4 * N, 1'b0, 1'b0, 2'b11);

    // Another master pulls SDA low while we send a 1 with SCL high.
    issue("arb", 3'd3, 1'b1);
    seen_done = 1'b0;
    k = 0;
    while (scl_oe && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    slave_sda_low = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 30) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
      if (arb_lost) seen = 1'b1;
      k++;
    end
    chk("arb.lost", 32'(seen), 32'd1);
    chk("arb.oe", 32'({scl_oe, sda_oe}), 32'd0);
    @(posedge clk);
    #1;
    chk("arb.pulse", 32'(arb_lost), 32'd0);
    chk("arb.ready", 32'(cmd_ready), 32'd1);
    slave_sda_low = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    chk("arb.no_done", 32'(seen_done), 32'd0);
    chk("arb.busy_clear", 32'(bus_busy), 32'd0);

`ifdef I2C_STRETCH_TIMEOUT_EN
    slave_scl_low = 1'b1;
    issue("tmo", 3'd3, 1'b0);
    seen = 1'b0;
    seen_done = 1'b0;
    k = 0;
    while (!seen && k < 400) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
      if (timeout) seen = 1'b1;
      k++;
    end
    chk("tmo.fired", 32'(seen), 32'd1);
    chk("tmo.oe", 32'({scl_oe, sda_oe}), 32'd0);
    chk("tmo.no_done", 32'(seen_done), 32'd0);
    @(posedge clk);
    #1;
    chk("tmo.pulse", 32'(timeout), 32'd0);
    chk("tmo.ready", 32'(cmd_ready), 32'd1);
    slave_scl_low = 1'b0;
    repeat (4) @(posedge clk);
    #1;
`else
    chk("tmo.tied", 32'(timeout), 32'd0);
`endif

    // Reset in the middle of a WRITE 0 releases both lines immediately.
    issue("rstmid", 3'd3, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid.driving", 32'(sda_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.oe", 32'({scl_oe, sda_oe}), 32'd0);
    chk("rstmid.ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
